// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a parallel RGB LCD panel: h/v counters, an early pixel
// request stage and registered panel pins aligned two clocks behind the counters.
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BP     = 43,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 8,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 12,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned RGB_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_req,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y,
  output logic             frame_start,
  input  logic [RGB_W-1:0] pix_rgb,
  output logic             lcd_de,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic [RGB_W-1:0] lcd_rgb,
  output logic             busy
);

  // Totals must fit the 10-bit counters (<= 1024).
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  // StArm holds the counters at 0 for one clock so the first request lands two
  // clocks after the en sample.
  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  state_e     state_q, state_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  logic run;
  logic req_d, fs_d, hs_a_d, vs_a_d;
  logic hs_a, vs_a;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      StIdle: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = StArm;
      end
      StArm: begin
        state_d = StRun;
      end
      StRun: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!en) state_d = StIdle;
          end else begin
            v_d = v_q + 10'd1;
          end
        end else begin
          h_d = h_q + 10'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    run    = (state_q == StRun);
    req_d  = run && (h_q < H_ACT) && (v_q < V_ACT);
    fs_d   = run && (h_q == '0) && (v_q == '0);
    hs_a_d = run && (h_q >= H_SYNC_S) && (h_q < H_SYNC_E);
    vs_a_d = run && (v_q >= V_SYNC_S) && (v_q < V_SYNC_E);
  end

  // Stage 1: request to the pixel source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_a        <= 1'b0;
      vs_a        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pix_req     <= req_d;
      pix_x       <= h_q;
      pix_y       <= v_q;
      frame_start <= fs_d;
      hs_a        <= hs_a_d;
      vs_a        <= vs_a_d;
      busy        <= run;
    end
  end

  // Stage 2: panel pins, all aligned with the captured pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_de  <= 1'b0;
      lcd_rgb <= '0;
      lcd_hs  <= ~HS_POL;
      lcd_vs  <= ~VS_POL;
    end else begin
      lcd_de  <= pix_req;
      lcd_rgb <= pix_req ? pix_rgb : '0;
      lcd_hs  <= hs_a ~^ HS_POL;
      lcd_vs  <= vs_a ~^ VS_POL;
    end
  end

endmodule
